// File: rtl/adsr_envelope.sv
// Four-phase ADSR amplitude envelope; all state/volume updates happen on prescaler ticks.
// Gate rising edges are latched between ticks so sub-tick pulses still trigger an attack.
module adsr_envelope #(
  parameter int VOL_BITS      = 8,
  parameter int RATE_BITS     = 8,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate,
  input  logic [RATE_BITS-1:0] attack,
  input  logic [RATE_BITS-1:0] decay,
  input  logic [VOL_BITS-1:0]  sustain,
  input  logic [RATE_BITS-1:0] rel,
  output logic [VOL_BITS-1:0]  volume,
  output logic [2:0]           state,
  output logic                 active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [VOL_BITS-1:0] VMAX = '1;
  localparam logic [VOL_BITS-1:0] ONE  = {{(VOL_BITS-1){1'b0}}, 1'b1};

  state_t                 st;
  logic [PRESCALE_BITS-1:0] presc;
  logic                   tick;
  logic                   gate_q;
  logic                   trig_pend;
  logic [RATE_BITS-1:0]   acc;
  logic [RATE_BITS-1:0]   rate;
  logic [RATE_BITS:0]     sum;
  logic                   step;

  assign state = st;
  assign tick  = &presc;

  always_comb begin
    rate = '0;
    case (st)
      S_ATTACK:  rate = attack;
      S_DECAY:   rate = decay;
      S_RELEASE: rate = rel;
      default:   rate = '0;
    endcase
  end

  assign sum  = {1'b0, acc} + {1'b0, rate};
  assign step = sum[RATE_BITS];

  // An edge landing on the tick cycle is consumed by that tick rather than held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      gate_q    <= 1'b0;
      trig_pend <= 1'b0;
    end else begin
      presc  <= presc + 1'b1;
      gate_q <= gate;
      if (tick)
        trig_pend <= 1'b0;
      else if (gate && !gate_q)
        trig_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      volume <= '0;
      active <= 1'b0;
      acc    <= '0;
    end else if (tick) begin
      case (st)
        S_IDLE: begin
          volume <= '0;
          if (gate || trig_pend) begin
            st     <= S_ATTACK;
            active <= 1'b1;
            acc    <= '0;
          end
        end
        S_ATTACK: begin
          if (!gate) begin
            st  <= S_RELEASE;
            acc <= '0;
          end else if (volume == VMAX) begin
            st  <= S_DECAY;
            acc <= '0;
          end else begin
            acc <= sum[RATE_BITS-1:0];
            if (step)
              volume <= volume + ONE;
          end
        end
        S_DECAY: begin
          if (!gate) begin
            st  <= S_RELEASE;
            acc <= '0;
          end else if (trig_pend) begin
            st  <= S_ATTACK;
            acc <= '0;
          end else if (volume <= sustain) begin
            st  <= S_SUSTAIN;
            acc <= '0;
          end else begin
            acc <= sum[RATE_BITS-1:0];
            if (step)
              volume <= (volume - ONE < sustain) ? sustain : volume - ONE;
          end
        end
        S_SUSTAIN: begin
          // Slew one LSB per tick toward the live sustain level to avoid clicks.
          if (!gate) begin
            st  <= S_RELEASE;
            acc <= '0;
          end else if (trig_pend) begin
            st  <= S_ATTACK;
            acc <= '0;
          end else if (volume < sustain) begin
            volume <= volume + ONE;
          end else if (volume > sustain) begin
            volume <= volume - ONE;
          end
        end
        S_RELEASE: begin
          if (gate || trig_pend) begin
            st  <= S_ATTACK;
            acc <= '0;
          end else if (volume == '0) begin
            st     <= S_IDLE;
            active <= 1'b0;
            acc    <= '0;
          end else begin
            acc <= sum[RATE_BITS-1:0];
            if (step)
              volume <= volume - ONE;
          end
        end
        default: begin
          st     <= S_IDLE;
          volume <= '0;
          active <= 1'b0;
          acc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope at PRESCALE_BITS=2 (tick every 4 clk): vector table plus corner sequences.
module tb_adsr_envelope;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] attack = 8'd0;
  logic [7:0] decay = 8'd0;
  logic [7:0] sustain = 8'd0;
  logic [7:0] rel = 8'd0;
  logic [7:0] volume;
  logic [2:0] state;
  logic       active;

  int n_tests = 0;
  int n_fail  = 0;

  adsr_envelope #(.VOL_BITS(8), .RATE_BITS(8), .PRESCALE_BITS(2)) dut (
    .clk(clk), .rst(rst), .gate(gate), .attack(attack), .decay(decay),
    .sustain(sustain), .rel(rel), .volume(volume), .state(state), .active(active)
  );

  always #5 clk = ~clk;

  // Reference prescaler: tells the bench which edge is a tick edge.
  logic [1:0] tb_presc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_presc <= 2'd0;
    else     tb_presc <= tb_presc + 2'd1;
  end

  typedef struct {
    string      name;
    logic [7:0] vol;
    logic [2:0] st;
    logic       act;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      name;
    logic       g;
    int         ticks;
    logic [7:0] vol;
    logic [2:0] st;
    logic       act;
  } vec_t;
  vec_t vt[14];

  task automatic next_tick();
    do @(negedge clk); while (tb_presc != 2'd3);
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [7:0] v, input logic [2:0] s, input logic a);
    exp_t e;
    e.name = nm; e.vol = v; e.st = s; e.act = a;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      if (volume !== e.vol || state !== e.st || active !== e.act) begin
        n_fail++;
        $display("FAIL %s: got vol=%0d state=%0d active=%0d, wanted vol=%0d state=%0d active=%0d",
                 e.name, volume, state, active, e.vol, e.st, e.act);
      end
    end
  endtask

  task automatic step_check(input string nm, input int ticks, input logic [7:0] v,
                            input logic [2:0] s, input logic a);
    push_exp(nm, v, s, a);
    for (int i = 0; i < ticks; i++) next_tick();
    check_pop();
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      gate = vt[i].g;
      step_check(vt[i].name, vt[i].ticks, vt[i].vol, vt[i].st, vt[i].act);
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin next_tick(); n++; end
    n_tests++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d after %0d ticks, wanted %0d", nm, state, n, s);
    end
  endtask

  task automatic wait_vol(input string nm, input logic [7:0] v, input int budget);
    int n = 0;
    while (volume !== v && n < budget) begin next_tick(); n++; end
    n_tests++;
    if (volume !== v) begin
      n_fail++;
      $display("FAIL %s: volume=%0d after %0d ticks, wanted %0d", nm, volume, n, v);
    end
  endtask

  initial begin
    // Full ADSR, attack=128: +1 every 2 ticks; tick 0 is the IDLE->ATTACK tick.
    vt[0]  = '{"atk_enter", 1'b1, 1,   8'd0,   3'd1, 1'b1};
    vt[1]  = '{"atk_k1",    1'b1, 1,   8'd0,   3'd1, 1'b1};
    vt[2]  = '{"atk_k2",    1'b1, 1,   8'd1,   3'd1, 1'b1};
    vt[3]  = '{"atk_k10",   1'b1, 8,   8'd5,   3'd1, 1'b1};
    vt[4]  = '{"atk_k110",  1'b1, 100, 8'd55,  3'd1, 1'b1};
    vt[5]  = '{"atk_k509",  1'b1, 399, 8'd254, 3'd1, 1'b1};
    vt[6]  = '{"atk_k510",  1'b1, 1,   8'd255, 3'd1, 1'b1};
    vt[7]  = '{"decay_ent", 1'b1, 1,   8'd255, 3'd2, 1'b1};
    // Release from 97 at rel=64: -1 every 4 ticks.
    vt[8]  = '{"rel_enter", 1'b0, 1,   8'd97,  3'd4, 1'b1};
    vt[9]  = '{"rel_k3",    1'b0, 3,   8'd97,  3'd4, 1'b1};
    vt[10] = '{"rel_k4",    1'b0, 1,   8'd96,  3'd4, 1'b1};
    vt[11] = '{"rel_k387",  1'b0, 383, 8'd1,   3'd4, 1'b1};
    vt[12] = '{"rel_k388",  1'b0, 1,   8'd0,   3'd4, 1'b1};
    vt[13] = '{"rel_idle",  1'b0, 1,   8'd0,   3'd0, 1'b0};

    // Reset state and quiet idle
    #3;
    push_exp("reset_async", 8'd0, 3'd0, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step_check("idle_hold", 1, 8'd0, 3'd0, 1'b0);

    // Full ADSR
    attack = 8'd128; decay = 8'd255; sustain = 8'd100; rel = 8'd64;
    apply_vecs(0, 7);
    wait_state("decay_to_sustain", 3'd3, 400);
    step_check("sustain_level", 0, 8'd100, 3'd3, 1'b1);

    // Sustain tracking
    sustain = 8'd97;
    step_check("track_99", 1, 8'd99, 3'd3, 1'b1);
    step_check("track_98", 1, 8'd98, 3'd3, 1'b1);
    step_check("track_97", 1, 8'd97, 3'd3, 1'b1);
    step_check("track_hold", 3, 8'd97, 3'd3, 1'b1);

    apply_vecs(8, 13);

    // Short pulse: one clk high, between ticks
    gate = 1'b1;
    @(posedge clk); #1;
    gate = 1'b0;
    step_check("pulse_attack", 1, 8'd0, 3'd1, 1'b1);
    step_check("pulse_release", 1, 8'd0, 3'd4, 1'b1);
    step_check("pulse_idle", 1, 8'd0, 3'd0, 1'b0);

    // Release retrigger from 150
    attack = 8'd255; rel = 8'd255; sustain = 8'd100;
    gate = 1'b1;
    wait_vol("retrig_reach180", 8'd180, 400);
    gate = 1'b0;
    step_check("retrig_rel180", 1, 8'd180, 3'd4, 1'b1);
    wait_vol("retrig_reach150", 8'd150, 100);
    gate = 1'b1;
    step_check("retrig_atk150", 1, 8'd150, 3'd1, 1'b1);
    step_check("retrig_atk153", 4, 8'd153, 3'd1, 1'b1);

    // Asynchronous reset mid-ramp
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    step_check("reset_midramp", 0, 8'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    attack = 8'd0;
    @(posedge clk); #1;
    step_check("post_reset_idle", 0, 8'd0, 3'd0, 1'b0);

    // Freeze: attack=0 holds ATTACK at 0
    step_check("freeze_enter", 1, 8'd0, 3'd1, 1'b1);
    for (int i = 0; i < 1000; i++) step_check("freeze_hold", 1, 8'd0, 3'd1, 1'b1);
    gate = 1'b0;
    step_check("freeze_release", 1, 8'd0, 3'd4, 1'b1);
    step_check("freeze_idle", 1, 8'd0, 3'd0, 1'b0);

    // sustain == VMAX: DECAY exits on its first tick
    attack = 8'd255; sustain = 8'd255;
    gate = 1'b1;
    wait_state("vmax_reach_decay", 3'd2, 700);
    step_check("vmax_decay_vol", 0, 8'd255, 3'd2, 1'b1);
    step_check("vmax_sustain", 1, 8'd255, 3'd3, 1'b1);
    gate = 1'b0;
    step_check("vmax_release", 1, 8'd255, 3'd4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
